// File: rtl/wb_regfile_if.sv
// MEM/WB writeback and ID-stage read signals of the register file, grouped as one bus.
// The master drives writeback and read addresses; the slave returns read data and writeback status.
interface wb_regfile_if;
  logic        MemReg_i;
  logic        RegW_i;
  logic [31:0] dataRead_i;
  logic [31:0] ALUresult_i;
  logic [4:0]  RegDestination_i;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data_o;
  logic        wb_valid_o;
  logic [15:0] wb_count;

  modport master (
    output MemReg_i, RegW_i, dataRead_i, ALUresult_i, RegDestination_i, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data_o, wb_valid_o, wb_count
  );

  modport slave (
    input  MemReg_i, RegW_i, dataRead_i, ALUresult_i, RegDestination_i, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data_o, wb_valid_o, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// 31x32 register file with writeback select, zero-latency reads, same-cycle bypass and commit counter.
// Writes commit on the rising clk edge; init clears storage and the counter asynchronously.
module wb_regfile (
  input logic         clk,
  input logic         init,
  wb_regfile_if.slave bus
);

  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];
  logic [15:0] wb_count_q;
  logic [15:0] wb_count_d;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign wb_data  = bus.MemReg_i ? bus.dataRead_i : bus.ALUresult_i;
  assign wb_valid = bus.RegW_i && (bus.RegDestination_i != 5'd0) && !init;

  always_comb begin
    wb_count_d = wb_count_q;
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_valid && (bus.RegDestination_i == 5'(i))) begin
        regs_d[i] = wb_data;
      end
    end
    if (wb_valid) begin
      wb_count_d = wb_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wb_count_q <= wb_count_d;
    end
  end

  // Address 0 and init force zero; the bypass beats storage for a matching committing write.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.rs_addr == 5'(i)) rs_val = regs_q[i];
      if (bus.rt_addr == 5'(i)) rt_val = regs_q[i];
    end
    if (wb_valid && (bus.rs_addr == bus.RegDestination_i)) rs_val = wb_data;
    if (wb_valid && (bus.rt_addr == bus.RegDestination_i)) rt_val = wb_data;
    if (init || (bus.rs_addr == 5'd0)) rs_val = '0;
    if (init || (bus.rt_addr == 5'd0)) rt_val = '0;
  end

  assign bus.rs_data    = rs_val;
  assign bus.rt_data    = rt_val;
  assign bus.wb_data_o  = wb_data;
  assign bus.wb_valid_o = wb_valid;
  assign bus.wb_count   = wb_count_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port init, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port MemReg_i, input, 1 bit: writeback source select from MEM/WB (1 = load data, 0 = ALU result).
REQ-004 The block SHALL have port RegW_i, input, 1 bit: writeback enable from MEM/WB.
REQ-005 The block SHALL have port dataRead_i, input, 32 bits: memory load data from MEM/WB.
REQ-006 The block SHALL have port ALUresult_i, input, 32 bits: ALU result from MEM/WB.
REQ-007 The block SHALL have port RegDestination_i, input, 5 bits: destination register number from MEM/WB.
REQ-008 The block SHALL have ports rs_addr and rt_addr, inputs, 5 bits each: ID-stage read addresses.
REQ-009 The block SHALL have ports rs_data and rt_data, outputs, 32 bits each: ID-stage read data.
REQ-010 The block SHALL have port wb_data_o, output, 32 bits: selected writeback value, for forwarding logic.
REQ-011 The block SHALL have port wb_valid_o, output, 1 bit: a committing write is present this cycle.
REQ-012 The block SHALL have port wb_count, output, 16 bits: count of committed register writes.

Function
REQ-013 The block SHALL drive wb_data_o = MemReg_i ? dataRead_i : ALUresult_i, combinationally, regardless of RegW_i.
REQ-014 The block SHALL drive wb_valid_o = RegW_i & (RegDestination_i != 0) & ~init, combinationally.
REQ-015 The block SHALL hold 31 writable 32-bit registers r1..r31; r0 is not storage and SHALL read as 0.
REQ-016 On each rising clk edge with wb_valid_o=1, the block SHALL store wb_data_o into r[RegDestination_i]; otherwise storage SHALL be unchanged.
REQ-017 A write to r0 (RegW_i=1, RegDestination_i=0) SHALL be ignored and SHALL NOT increment wb_count.
REQ-018 Reads SHALL be combinational (zero-cycle latency): rs_data = r[rs_addr], rt_data = r[rt_addr].
REQ-019 Same-cycle bypass: when wb_valid_o=1 and rs_addr equals RegDestination_i, rs_data SHALL equal wb_data_o; likewise for rt_addr/rt_data. Both ports may bypass simultaneously.
REQ-020 rs_addr=0 or rt_addr=0 SHALL return 0 on the corresponding port, regardless of bypass.
REQ-021 wb_count SHALL increment by 1 on each rising edge with wb_valid_o=1, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-022 Back-to-back writes to the same register SHALL leave the last written value; no write SHALL be lost or merged.

Reset
REQ-023 Assertion of init SHALL immediately, without waiting for clk, clear r1..r31 to 32'h0 and wb_count to 16'h0.
REQ-024 While init=1, no register write and no wb_count increment SHALL occur, bypass SHALL be disabled, and rs_data/rt_data SHALL read 32'h0.
REQ-025 A write whose clock edge coincides with init=1 SHALL be discarded.
REQ-026 After init deasserts, the first rising edge with wb_valid_o=1 SHALL commit normally.

Verification
REQ-027 The bench SHALL cover ALU write: RegW_i=1, MemReg_i=0, ALUresult_i=32'h0000_1234, RegDestination_i=5, edge; then rs_addr=5 with RegW_i=0 -> rs_data=32'h0000_1234, wb_count=1.
REQ-028 The bench SHALL cover load write with bypass: MemReg_i=1, dataRead_i=32'hDEAD_BEEF, RegDestination_i=7, RegW_i=1, rs_addr=rt_addr=7 before the edge -> rs_data=rt_data=32'hDEAD_BEEF in the same cycle; after the edge, with RegW_i=0 -> both still 32'hDEAD_BEEF.
REQ-029 The bench SHALL cover r0 protection: RegW_i=1, RegDestination_i=0, ALUresult_i=32'hFFFF_FFFF, edge -> rs_addr=0 gives 0, wb_valid_o=0 during the write cycle, wb_count unchanged.
REQ-030 The bench SHALL cover asynchronous reset mid-operation: write r3=32'h55, then pulse init between clock edges -> rs_data for r3 is 0 immediately and wb_count=0; a write presented while init=1 leaves r3=0.
REQ-031 The bench SHALL cover counter wrap: 65536 committed writes -> wb_count returns to 16'h0000; one more commit -> 16'h0001.
REQ-032 The bench SHALL cover RegW_i=0 with valid data: ALUresult_i=32'hAAAA, RegDestination_i=9, edge -> r9 unchanged (0), wb_data_o=32'hAAAA, wb_count unchanged.
